// File: rtl/rv_fetch_pkg.sv
// Shared definitions for the RV64 fetch stage.
//   XLEN / ILEN   : address and instruction widths
//   NOP_INST_WORD : canonical bubble, addi x0,x0,0
//   PC_STEP       : sequential fetch increment in bytes
//   fetch_state_t : fetch FSM states
package rv_fetch_pkg;

  localparam int unsigned XLEN = 64;
  localparam int unsigned ILEN = 32;

  localparam logic [ILEN-1:0] NOP_INST_WORD = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP       = 64'd4;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/pc_register.sv
// Program counter storage with synchronous active-high reset.
//   clk, reset : clock and sync reset (reset loads RESET_PC, overrides load_en)
//   load_en    : update PC with next_pc on this edge
//   next_pc    : value to load, chosen by the parent
//   pc         : current PC
module pc_register
  import rv_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 64'h0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load_en,
  input  logic [XLEN-1:0] next_pc,
  output logic [XLEN-1:0] pc
);

  logic [XLEN-1:0] pc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else if (load_en) begin
      pc_q <= next_pc;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, addresses a combinational instruction memory and
// captures the returned word plus its PC into the IF/ID register.
//   clk, reset          : clock, sync active-high reset
//   Instruction         : memory word for Inst_Address, same cycle
//   Stall               : hold PC and IF/ID
//   Branch_Taken/Target : redirect request (overrides Stall, leaves HALT)
//   Inst_Address        : current PC
//   IF_ID_PC/Instruction/Valid : pipeline register to decode
//   Misaligned_Target   : one-cycle pulse after a redirect with target[1:0] != 0
//   Halted              : fetch ran past MEM_BYTES
//   Fetch_Count         : number of valid captures, wraps at 2^32
module instruction_fetch_unit
  import rv_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 64'h0,
  parameter logic [XLEN-1:0] MEM_BYTES = 64'd16,
  parameter logic [ILEN-1:0] NOP_INST  = NOP_INST_WORD
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [ILEN-1:0] Instruction,
  input  logic            Stall,
  input  logic            Branch_Taken,
  input  logic [XLEN-1:0] Branch_Target,
  output logic [XLEN-1:0] Inst_Address,
  output logic [XLEN-1:0] IF_ID_PC,
  output logic [ILEN-1:0] IF_ID_Instruction,
  output logic            IF_ID_Valid,
  output logic            Misaligned_Target,
  output logic            Halted,
  output logic [31:0]     Fetch_Count
);

  fetch_state_t    state_q;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_next;
  logic            pc_load;
  logic [XLEN-1:0] target_aligned;
  logic            pc_in_range;

  logic [XLEN-1:0] if_id_pc_q;
  logic [ILEN-1:0] if_id_inst_q;
  logic            if_id_valid_q;
  logic            misaligned_q;
  logic [31:0]     fetch_count_q;

  assign target_aligned = {Branch_Target[XLEN-1:2], 2'b00};
  assign pc_in_range    = (pc < MEM_BYTES);

  // Next-PC select; reset priority lives in pc_register.
  always_comb begin
    pc_load = 1'b0;
    pc_next = pc + PC_STEP;
    if (Branch_Taken) begin
      pc_load = 1'b1;
      pc_next = target_aligned;
    end else if ((state_q == RUN) && !Stall && pc_in_range) begin
      pc_load = 1'b1;
    end
  end

  pc_register #(
    .RESET_PC (RESET_PC)
  ) u_pc_register (
    .clk     (clk),
    .reset   (reset),
    .load_en (pc_load),
    .next_pc (pc_next),
    .pc      (pc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= RUN;
      if_id_pc_q    <= '0;
      if_id_inst_q  <= NOP_INST;
      if_id_valid_q <= 1'b0;
      misaligned_q  <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      misaligned_q <= 1'b0;
      if (Branch_Taken) begin
        state_q       <= RUN;
        if_id_pc_q    <= '0;
        if_id_inst_q  <= NOP_INST;
        if_id_valid_q <= 1'b0;
        misaligned_q  <= |Branch_Target[1:0];
      end else if (state_q == HALT) begin
        // Bubble already loaded on entry; Stall is irrelevant here.
        if_id_valid_q <= 1'b0;
      end else if (Stall) begin
        // Hold everything.
      end else if (!pc_in_range) begin
        state_q       <= HALT;
        if_id_pc_q    <= '0;
        if_id_inst_q  <= NOP_INST;
        if_id_valid_q <= 1'b0;
      end else begin
        if_id_pc_q    <= pc;
        if_id_inst_q  <= Instruction;
        if_id_valid_q <= 1'b1;
        fetch_count_q <= fetch_count_q + 32'd1;
      end
    end
  end

  assign Inst_Address      = pc;
  assign IF_ID_PC          = if_id_pc_q;
  assign IF_ID_Instruction = if_id_inst_q;
  assign IF_ID_Valid       = if_id_valid_q;
  assign Misaligned_Target = misaligned_q;
  assign Halted            = (state_q == HALT);
  assign Fetch_Count       = fetch_count_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        Stall = 1'b0;
  logic        Branch_Taken = 1'b0;
  logic [63:0] Branch_Target = 64'd0;
  logic [31:0] Instruction;
  logic [63:0] Inst_Address;
  logic [63:0] IF_ID_PC;
  logic [31:0] IF_ID_Instruction;
  logic        IF_ID_Valid;
  logic        Misaligned_Target;
  logic        Halted;
  logic [31:0] Fetch_Count;

  logic [31:0] mem [4];
  logic [31:0] plan [4];

  // Reference model state
  logic [63:0] m_pc;
  logic [63:0] m_if_pc;
  logic [31:0] m_if_inst;
  logic        m_valid;
  logic        m_mis;
  logic        m_halted;
  logic [31:0] m_count;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  // Combinational instruction memory; out-of-range returns a poison word.
  assign Instruction = (Inst_Address < 64'd16) ? mem[Inst_Address[3:2]] : 32'hBAD0_BAD0;

  instruction_fetch_unit dut (
    .clk               (clk),
    .reset             (reset),
    .Instruction       (Instruction),
    .Stall             (Stall),
    .Branch_Taken      (Branch_Taken),
    .Branch_Target     (Branch_Target),
    .Inst_Address      (Inst_Address),
    .IF_ID_PC          (IF_ID_PC),
    .IF_ID_Instruction (IF_ID_Instruction),
    .IF_ID_Valid       (IF_ID_Valid),
    .Misaligned_Target (Misaligned_Target),
    .Halted            (Halted),
    .Fetch_Count       (Fetch_Count)
  );

  // One clock edge: advance the model with the inputs present at the edge,
  // then settle 1 time unit past the edge for sampling.
  task automatic cycle();
    @(posedge clk);
    if (reset) begin
      m_pc = 64'd0; m_if_pc = 64'd0; m_if_inst = NOP; m_valid = 1'b0;
      m_mis = 1'b0; m_halted = 1'b0; m_count = 32'd0;
    end else begin
      m_mis = 1'b0;
      if (Branch_Taken) begin
        m_pc = Branch_Target & ~64'd3;
        m_if_pc = 64'd0; m_if_inst = NOP; m_valid = 1'b0;
        m_mis = (Branch_Target % 4) != 0;
        m_halted = 1'b0;
      end else if (m_halted) begin
        m_valid = 1'b0;
      end else if (Stall) begin
        // nothing moves
      end else if (m_pc >= 64'd16) begin
        m_halted = 1'b1; m_if_inst = NOP; m_valid = 1'b0;
      end else begin
        m_if_pc = m_pc;
        m_if_inst = mem[m_pc / 4];
        m_valid = 1'b1;
        m_pc = m_pc + 64'd4;
        m_count = m_count + 32'd1;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cycle();
    cycle();
    n_checks++; if (Inst_Address !== 64'd0) $display("FAIL reset_pc got=%h exp=0", Inst_Address); else n_pass++;
    n_checks++; if (IF_ID_Valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", IF_ID_Valid); else n_pass++;
    n_checks++; if (IF_ID_Instruction !== NOP) $display("FAIL reset_inst got=%h exp=%h", IF_ID_Instruction, NOP); else n_pass++;
    n_checks++; if (IF_ID_PC !== 64'd0) $display("FAIL reset_ifpc got=%h exp=0", IF_ID_PC); else n_pass++;
    n_checks++; if (Fetch_Count !== 32'd0) $display("FAIL reset_count got=%0d exp=0", Fetch_Count); else n_pass++;
    n_checks++; if (Halted !== 1'b0 || Misaligned_Target !== 1'b0) $display("FAIL reset_flags got=%b%b exp=00", Halted, Misaligned_Target); else n_pass++;
  endtask

  task automatic test_sequential();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (Inst_Address !== 64'(i * 4)) $display("FAIL seq_addr%0d got=%h exp=%h", i, Inst_Address, 64'(i * 4)); else n_pass++;
      cycle();
      n_checks++; if (IF_ID_Instruction !== plan[i]) $display("FAIL seq_inst%0d got=%h exp=%h", i, IF_ID_Instruction, plan[i]); else n_pass++;
      n_checks++; if (IF_ID_PC !== 64'(i * 4) || IF_ID_Valid !== 1'b1) $display("FAIL seq_ifpc%0d got=%h/%b exp=%h/1", i, IF_ID_PC, IF_ID_Valid, 64'(i * 4)); else n_pass++;
    end
    n_checks++; if (Fetch_Count !== 32'd4) $display("FAIL seq_count got=%0d exp=4", Fetch_Count); else n_pass++;
  endtask

  task automatic test_halt();
    n_checks++; if (Inst_Address !== 64'd16) $display("FAIL halt_pc16 got=%h exp=10", Inst_Address); else n_pass++;
    cycle();
    n_checks++; if (Halted !== 1'b1 || IF_ID_Valid !== 1'b0) $display("FAIL halt_enter got=%b/%b exp=1/0", Halted, IF_ID_Valid); else n_pass++;
    n_checks++; if (IF_ID_Instruction !== NOP) $display("FAIL halt_nop got=%h exp=%h", IF_ID_Instruction, NOP); else n_pass++;
    Stall = 1'b1;  // no effect in HALT
    for (int i = 0; i < 5; i++) begin
      cycle();
      n_checks++; if (Inst_Address !== 64'd16 || Fetch_Count !== 32'd4 || Halted !== 1'b1) $display("FAIL halt_hold%0d got=%h/%0d/%b exp=10/4/1", i, Inst_Address, Fetch_Count, Halted); else n_pass++;
    end
    Stall = 1'b0;
  endtask

  task automatic test_stall();
    Branch_Taken = 1'b1; Branch_Target = 64'd4;
    cycle();
    Branch_Taken = 1'b0;
    n_checks++; if (Inst_Address !== 64'd4 || Halted !== 1'b0) $display("FAIL stall_setup got=%h/%b exp=4/0", Inst_Address, Halted); else n_pass++;
    cycle();
    Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_checks++; if (Inst_Address !== 64'd8) $display("FAIL stall_pc%0d got=%h exp=8", i, Inst_Address); else n_pass++;
      n_checks++; if (IF_ID_PC !== 64'd4 || IF_ID_Instruction !== 32'h009A84B3 || IF_ID_Valid !== 1'b1) $display("FAIL stall_ifid%0d got=%h/%h/%b exp=4/009a84b3/1", i, IF_ID_PC, IF_ID_Instruction, IF_ID_Valid); else n_pass++;
    end
    Stall = 1'b0;
    cycle();
    n_checks++; if (IF_ID_Instruction !== 32'h00148493 || IF_ID_PC !== 64'd8) $display("FAIL stall_release got=%h/%h exp=00148493/8", IF_ID_Instruction, IF_ID_PC); else n_pass++;
  endtask

  task automatic test_branch_over_stall();
    n_checks++; if (Inst_Address !== 64'd12) $display("FAIL bos_pc12 got=%h exp=c", Inst_Address); else n_pass++;
    Branch_Taken = 1'b1; Stall = 1'b1; Branch_Target = 64'd4;
    cycle();
    Branch_Taken = 1'b0; Stall = 1'b0;
    n_checks++; if (Inst_Address !== 64'd4) $display("FAIL bos_redirect got=%h exp=4", Inst_Address); else n_pass++;
    n_checks++; if (IF_ID_Valid !== 1'b0 || IF_ID_Instruction !== NOP || IF_ID_PC !== 64'd0) $display("FAIL bos_flush got=%b/%h/%h exp=0/00000013/0", IF_ID_Valid, IF_ID_Instruction, IF_ID_PC); else n_pass++;
    n_checks++; if (Misaligned_Target !== 1'b0) $display("FAIL bos_mis got=%b exp=0", Misaligned_Target); else n_pass++;
    cycle();
    n_checks++; if (IF_ID_Instruction !== 32'h009A84B3 || IF_ID_Valid !== 1'b1) $display("FAIL bos_resume got=%h/%b exp=009a84b3/1", IF_ID_Instruction, IF_ID_Valid); else n_pass++;
  endtask

  task automatic test_halt_redirect();
    for (int k = 0; k < 10 && Halted !== 1'b1; k++) cycle();
    n_checks++; if (Halted !== 1'b1) $display("FAIL hr_reach_halt got=%b exp=1 within 10 cycles", Halted); else n_pass++;
    Branch_Taken = 1'b1; Branch_Target = 64'd6;
    cycle();
    Branch_Taken = 1'b0;
    n_checks++; if (Inst_Address !== 64'd4 || Halted !== 1'b0) $display("FAIL hr_redirect got=%h/%b exp=4/0", Inst_Address, Halted); else n_pass++;
    n_checks++; if (Misaligned_Target !== 1'b1) $display("FAIL hr_mis_pulse got=%b exp=1", Misaligned_Target); else n_pass++;
    cycle();
    n_checks++; if (Misaligned_Target !== 1'b0) $display("FAIL hr_mis_clear got=%b exp=0", Misaligned_Target); else n_pass++;
    n_checks++; if (IF_ID_Instruction !== 32'h009A84B3 || IF_ID_PC !== 64'd4) $display("FAIL hr_resume got=%h/%h exp=009a84b3/4", IF_ID_Instruction, IF_ID_PC); else n_pass++;
  endtask

  task automatic test_reset_branch();
    n_checks++; if (Inst_Address !== 64'd8) $display("FAIL rb_pc8 got=%h exp=8", Inst_Address); else n_pass++;
    reset = 1'b1; Branch_Taken = 1'b1; Branch_Target = 64'd6;
    cycle();
    reset = 1'b0; Branch_Taken = 1'b0;
    n_checks++; if (Inst_Address !== 64'd0 || IF_ID_Valid !== 1'b0 || Fetch_Count !== 32'd0) $display("FAIL rb_state got=%h/%b/%0d exp=0/0/0", Inst_Address, IF_ID_Valid, Fetch_Count); else n_pass++;
    n_checks++; if (Misaligned_Target !== 1'b0) $display("FAIL rb_mis got=%b exp=0", Misaligned_Target); else n_pass++;
    cycle();
    n_checks++; if (Misaligned_Target !== 1'b0 || IF_ID_Instruction !== plan[0]) $display("FAIL rb_after got=%b/%h exp=0/%h", Misaligned_Target, IF_ID_Instruction, plan[0]); else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 4; i++) mem[i] = $urandom;
    for (int n = 0; n < 400; n++) begin
      reset        = ($urandom_range(0, 49) == 0);
      Stall        = ($urandom_range(0, 3) == 0);
      Branch_Taken = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 9) == 0) Branch_Target = {$urandom, $urandom};
      else Branch_Target = 64'($urandom_range(0, 23));
      cycle();
      n_checks++; if (Inst_Address !== m_pc) $display("FAIL rnd_pc@%0d got=%h exp=%h", n, Inst_Address, m_pc); else n_pass++;
      n_checks++; if (IF_ID_Valid !== m_valid) $display("FAIL rnd_valid@%0d got=%b exp=%b", n, IF_ID_Valid, m_valid); else n_pass++;
      n_checks++; if (IF_ID_Instruction !== m_if_inst) $display("FAIL rnd_inst@%0d got=%h exp=%h", n, IF_ID_Instruction, m_if_inst); else n_pass++;
      if (m_valid) begin
        n_checks++; if (IF_ID_PC !== m_if_pc) $display("FAIL rnd_ifpc@%0d got=%h exp=%h", n, IF_ID_PC, m_if_pc); else n_pass++;
      end
      n_checks++; if (Misaligned_Target !== m_mis) $display("FAIL rnd_mis@%0d got=%b exp=%b", n, Misaligned_Target, m_mis); else n_pass++;
      n_checks++; if (Halted !== m_halted) $display("FAIL rnd_halted@%0d got=%b exp=%b", n, Halted, m_halted); else n_pass++;
      n_checks++; if (Fetch_Count !== m_count) $display("FAIL rnd_count@%0d got=%0d exp=%0d", n, Fetch_Count, m_count); else n_pass++;
    end
    reset = 1'b0; Stall = 1'b0; Branch_Taken = 1'b0;
  endtask

  initial begin
    plan[0] = 32'h02853483;
    plan[1] = 32'h009A84B3;
    plan[2] = 32'h00148493;
    plan[3] = 32'h0E953823;
    for (int i = 0; i < 4; i++) mem[i] = plan[i];
    m_pc = '0; m_if_pc = '0; m_if_inst = NOP; m_valid = 1'b0;
    m_mis = 1'b0; m_halted = 1'b0; m_count = '0;

    test_reset();
    test_sequential();
    test_halt();
    test_stall();
    test_branch_over_stall();
    test_halt_redirect();
    test_reset_branch();
    test_random();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
